// File: rtl/mymem_axi_master.sv
`default_nettype none
// ============================================================================
// Module   : mymem_axi_master
// Purpose  : MEM-stage AXI-lite initiator. Turns one load/store request into a
//            single AW+W+B or AR+R transaction, stalls the pipeline until it
//            completes and then presents load data for one pipeline advance.
// Revision : 1.0  initial release
// ============================================================================
module mymem_axi_master #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_stall_i,
    output logic [31:0] mem_data_o,
    output logic        stallreq,
    output logic        bus_err_o,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic             TO_EN      = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      ABORT_DATA = 32'hDEAD_BEEF;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [31:0]        data_q, data_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               bready_q, bready_d;
    logic               arvalid_q, arvalid_d;
    logic               rready_q, rready_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, wait_st, timeout;

    // VALID/READY outputs are only ever high in their own state, so these
    // handshakes are already qualified by state.
    assign aw_hs   = awvalid_q & M_AXI_AWREADY;
    assign w_hs    = wvalid_q  & M_AXI_WREADY;
    assign b_hs    = bready_q  & M_AXI_BVALID;
    assign ar_hs   = arvalid_q & M_AXI_ARREADY;
    assign r_hs    = rready_q  & M_AXI_RVALID;
    assign any_hs  = aw_hs | w_hs | b_hs | ar_hs | r_hs;
    assign wait_st = (state_q == ST_WR_REQ)  || (state_q == ST_WR_RESP) ||
                     (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);
    assign timeout = TO_EN && wait_st && !any_hs && (cnt_q == TO_LAST);

    assign stallreq      = !rst && (((state_q == ST_IDLE) && mem_ce_i) || wait_st);
    assign mem_data_o    = data_q;
    assign bus_err_o     = err_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

    // Next-state, channel control and timeout logic
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        data_d    = data_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        err_d     = err_q;
        // Counter runs only while waiting on the slave; any handshake or
        // state change into/out of a wait state restarts it from zero.
        cnt_d     = (TO_EN && wait_st && !any_hs) ? cnt_q + 1'b1 : '0;

        case (state_q)
            ST_IDLE: begin
                if (mem_ce_i) begin
                    addr_d  = mem_addr_i;
                    wdata_d = mem_data_i;
                    wstrb_d = mem_sel_i;
                    if (mem_we_i) begin
                        state_d   = ST_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WR_REQ: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                // Both address and data accepted (now or earlier)
                if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_RD_ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (r_hs) begin
                    data_d   = M_AXI_RDATA;
                    rready_d = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!mem_stall_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            err_d     = 1'b1;
            data_d    = ABORT_DATA;
            state_d   = ST_DONE;
        end
    end

    // State and registered outputs; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            data_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            data_q    <= data_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mymem_axi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mymem_axi_master
// Purpose  : Self-checking bench: table vectors, hand-written corner cases and
//            random load/store traffic against a word-array reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mymem_axi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_ce_i = 1'b0, mem_we_i = 1'b0, mem_stall_i = 1'b0;
    logic [31:0] mem_addr_i = '0, mem_data_i = '0;
    logic [3:0]  mem_sel_i = '0;
    logic [31:0] mem_data_o;
    logic        stallreq, bus_err_o;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
    logic        M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
    logic [31:0] M_AXI_RDATA = '0;

    mymem_axi_master #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i), .mem_stall_i(mem_stall_i),
        .mem_data_o(mem_data_o), .stallreq(stallreq), .bus_err_o(bus_err_o),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0, proto_err = 0;
    int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
    int n_aw = 0, n_w = 0, n_ar = 0;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
    logic [3:0]  s_wstrb = '0;
    logic [31:0] smem    [0:255];
    logic [31:0] ref_mem [0:255];

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // AXI-lite slave with programmable ready/response delays; acts at negedge
    initial begin : slave
        bit f_aw, f_w, f_b, f_ar, f_r, have_aw, have_w, have_ar;
        int c_aw, c_w, c_ar, c_r;
        logic [31:0] m;
        f_aw = 0; f_w = 0; f_b = 0; f_ar = 0; f_r = 0;
        have_aw = 0; have_w = 0; have_ar = 0;
        c_aw = 0; c_w = 0; c_ar = 0; c_r = 0;
        for (int i = 0; i < 256; i++) smem[i] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                f_aw = 0; f_w = 0; f_b = 0; f_ar = 0; f_r = 0;
                have_aw = 0; have_w = 0; have_ar = 0;
                c_aw = 0; c_w = 0; c_ar = 0; c_r = 0;
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
                M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
            end else begin
                // handshakes completed at the posedge just passed
                if (f_aw) have_aw = 1;
                if (f_w)  have_w  = 1;
                if (f_b)  M_AXI_BVALID = 0;
                if (f_ar) begin have_ar = 1; c_r = 0; end
                if (f_r)  begin M_AXI_RVALID = 0; have_ar = 0; end
                if (have_aw && have_w) begin
                    m = smem[s_awaddr[9:2]];
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) m[8*b +: 8] = s_wdata[8*b +: 8];
                    smem[s_awaddr[9:2]] = m;
                    have_aw = 0; have_w = 0;
                    M_AXI_BVALID = 1;
                end
                if (M_AXI_AWVALID && !have_aw) begin
                    if (c_aw >= aw_dly) M_AXI_AWREADY = 1; else begin M_AXI_AWREADY = 0; c_aw++; end
                end else begin M_AXI_AWREADY = 0; c_aw = 0; end
                if (M_AXI_WVALID && !have_w) begin
                    if (c_w >= w_dly) M_AXI_WREADY = 1; else begin M_AXI_WREADY = 0; c_w++; end
                end else begin M_AXI_WREADY = 0; c_w = 0; end
                if (M_AXI_ARVALID && !have_ar) begin
                    if (c_ar >= ar_dly) M_AXI_ARREADY = 1; else begin M_AXI_ARREADY = 0; c_ar++; end
                end else begin M_AXI_ARREADY = 0; c_ar = 0; end
                if (have_ar && !M_AXI_RVALID) begin
                    if (c_r >= r_dly) begin
                        M_AXI_RVALID = 1;
                        M_AXI_RDATA  = smem[s_araddr[9:2]];
                    end else c_r++;
                end
                // handshakes that will occur at the coming posedge
                f_aw = M_AXI_AWVALID && M_AXI_AWREADY;
                f_w  = M_AXI_WVALID  && M_AXI_WREADY;
                f_b  = M_AXI_BVALID  && M_AXI_BREADY;
                f_ar = M_AXI_ARVALID && M_AXI_ARREADY;
                f_r  = M_AXI_RVALID  && M_AXI_RREADY;
                if (f_aw) begin s_awaddr = M_AXI_AWADDR; n_aw++; end
                if (f_w)  begin s_wdata = M_AXI_WDATA; s_wstrb = M_AXI_WSTRB; n_w++; end
                if (f_ar) begin s_araddr = M_AXI_ARADDR; n_ar++; end
            end
        end
    end

    // Protocol monitor: read/write exclusivity and VALID/READY held until handshake
    initial begin : monitor
        bit pv_aw, pv_w, pv_b, pv_ar, pv_r;
        pv_aw = 0; pv_w = 0; pv_b = 0; pv_ar = 0; pv_r = 0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                if (M_AXI_ARVALID && (M_AXI_AWVALID || M_AXI_WVALID)) proto_err++;
                if (!bus_err_o) begin
                    if (pv_aw && !M_AXI_AWVALID) proto_err++;
                    if (pv_w  && !M_AXI_WVALID)  proto_err++;
                    if (pv_b  && !M_AXI_BREADY)  proto_err++;
                    if (pv_ar && !M_AXI_ARVALID) proto_err++;
                    if (pv_r  && !M_AXI_RREADY)  proto_err++;
                end
            end
            pv_aw = !rst && M_AXI_AWVALID && !M_AXI_AWREADY;
            pv_w  = !rst && M_AXI_WVALID  && !M_AXI_WREADY;
            pv_b  = !rst && M_AXI_BREADY  && !M_AXI_BVALID;
            pv_ar = !rst && M_AXI_ARVALID && !M_AXI_ARREADY;
            pv_r  = !rst && M_AXI_RREADY  && !M_AXI_RVALID;
        end
    end

    // One pipeline access: hold request until stall clears, optionally hold DONE
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                             input logic [31:0] data, input int stall_cyc, input string tag);
        int aw0, w0, ar0, cyc, idx;
        bit done;
        logic [31:0] exp, mask, held;
        idx = widx(addr);
        exp = ref_mem[idx];
        aw0 = n_aw; w0 = n_w; ar0 = n_ar;
        @(negedge clk);
        mem_ce_i = 1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel;
        mem_data_i = data; mem_stall_i = (stall_cyc > 0);
        cyc = 0; done = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (!stallreq) done = 1;
        end
        check({tag, " done"}, 32'(done), 32'd1);
        if (we) begin
            mask = '0;
            for (int b = 0; b < 4; b++) if (sel[b]) mask[8*b +: 8] = 8'hFF;
            ref_mem[idx] = (ref_mem[idx] & ~mask) | (data & mask);
            check({tag, " aw count"}, 32'(n_aw - aw0), 32'd1);
            check({tag, " w count"},  32'(n_w - w0),   32'd1);
            check({tag, " ar count"}, 32'(n_ar - ar0), 32'd0);
            check({tag, " awaddr"},   s_awaddr, addr);
            check({tag, " wstrb"},    32'(s_wstrb), 32'(sel));
            check({tag, " wdata"},    s_wdata, data);
        end else begin
            check({tag, " rdata"},    mem_data_o, exp);
            check({tag, " ar count"}, 32'(n_ar - ar0), 32'd1);
            check({tag, " aw count"}, 32'(n_aw - aw0), 32'd0);
            check({tag, " araddr"},   s_araddr, addr);
        end
        held = mem_data_o;
        for (int k = 0; k < stall_cyc; k++) begin
            @(negedge clk);
            check({tag, " stallreq in DONE"}, 32'(stallreq), 32'd0);
            check({tag, " data held"}, mem_data_o, held);
        end
        mem_stall_i = 0; mem_ce_i = 0;
        if (stall_cyc > 0)
            check({tag, " no reissue"}, 32'(n_ar - ar0 + n_aw - aw0), 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int aw0, w0, cyc, cnt;
        bit done;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        vecs[0] = '{1'b1, 32'h100, 4'hF, 32'h1234_5678, 32'h0};
        vecs[1] = '{1'b0, 32'h100, 4'h0, 32'h0,         32'h1234_5678};
        vecs[2] = '{1'b1, 32'h104, 4'hF, 32'hFFFF_FFFF, 32'h0};
        vecs[3] = '{1'b1, 32'h104, 4'h2, 32'h0000_AB00, 32'h0};
        vecs[4] = '{1'b0, 32'h104, 4'h0, 32'h0,         32'hFFFF_ABFF};
        vecs[5] = '{1'b1, 32'h108, 4'h1, 32'h0000_00AA, 32'h0};
        vecs[6] = '{1'b1, 32'h108, 4'h8, 32'hCC00_0000, 32'h0};
        vecs[7] = '{1'b0, 32'h108, 4'h0, 32'h0,         32'hCC00_00AA};
        vecs[8] = '{1'b0, 32'h100, 4'h0, 32'h0,         32'h1234_5678};

        // reset state
        repeat (3) @(negedge clk);
        check("reset stallreq", 32'(stallreq), 0);
        check("reset valids", {27'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        check("reset addr/data", M_AXI_AWADDR | M_AXI_ARADDR | M_AXI_WDATA | 32'(M_AXI_WSTRB), 0);
        check("reset mem_data_o", mem_data_o, 0);
        check("reset bus_err", 32'(bus_err_o), 0);
        rst = 0;

        // table vectors (loads compared against hand-computed values)
        foreach (vecs[i]) begin
            do_access(vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].data, 0, $sformatf("vec%0d", i));
            if (!vecs[i].we) check($sformatf("vec%0d table exp", i), mem_data_o, vecs[i].exp);
        end

        // AWREADY three cycles late: W completes first, AW held, no early B
        aw_dly = 3; w_dly = 0;
        aw0 = n_aw; w0 = n_w;
        @(negedge clk);
        mem_ce_i = 1; mem_we_i = 1; mem_addr_i = 32'h10C; mem_sel_i = 4'hF; mem_data_i = 32'h5A5A_0001;
        @(negedge clk);
        check("late aw both valid", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd3);
        repeat (2) begin
            @(negedge clk);
            check("late aw W dropped/AW held/no B", {29'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 32'd4);
        end
        cyc = 0; done = 0;
        while (!done && cyc < 100) begin @(negedge clk); cyc++; if (!stallreq) done = 1; end
        check("late aw done", 32'(done), 1);
        check("late aw single write", 32'(n_aw - aw0) + 32'(n_w - w0), 32'd2);
        mem_ce_i = 0; aw_dly = 0;
        ref_mem[widx(32'h10C)] = 32'h5A5A_0001;
        do_access(0, 32'h10C, 4'h0, 0, 0, "late aw readback");

        // DONE held by external stall for 5 cycles with request still asserted
        do_access(0, 32'h100, 4'h0, 0, 5, "stall hold");

        // random traffic with random slave timing and DONE stalls
        for (int i = 0; i < 40; i++) begin
            aw_dly = $urandom_range(0, 4); w_dly = $urandom_range(0, 4);
            ar_dly = $urandom_range(0, 4); r_dly = $urandom_range(0, 4);
            do_access(1'($urandom_range(0, 1)), 32'h200 + 32'(4 * $urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 2), $sformatf("rnd%0d", i));
        end
        aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0;

        // timeout: slave never accepts AR
        ar_dly = 1000;
        @(negedge clk);
        mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h100;
        cyc = 0; cnt = 0; done = 0;
        while (!done && cyc < 50) begin
            @(negedge clk); cyc++;
            if (M_AXI_ARVALID) cnt++;
            if (!stallreq) done = 1;
        end
        check("timeout done", 32'(done), 1);
        check("timeout ARVALID cycles", 32'(cnt), 32'd8);
        check("timeout ARVALID low", 32'(M_AXI_ARVALID), 0);
        check("timeout bus_err", 32'(bus_err_o), 1);
        check("timeout data", mem_data_o, 32'hDEAD_BEEF);
        mem_ce_i = 0;
        @(negedge clk);
        check("timeout err sticky", 32'(bus_err_o), 1);
        ar_dly = 0;

        // reset during RD_DATA
        r_dly = 5;
        @(negedge clk);
        mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h100;
        cyc = 0; done = 0;
        while (!done && cyc < 30) begin @(negedge clk); cyc++; if (M_AXI_RREADY) done = 1; end
        check("reset-mid reached RD_DATA", 32'(done), 1);
        rst = 1;
        @(negedge clk);
        check("reset-mid valids", {27'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        check("reset-mid stallreq", 32'(stallreq), 0);
        check("reset-mid bus_err", 32'(bus_err_o), 0);
        rst = 0; mem_ce_i = 0; r_dly = 0;
        do_access(0, 32'h100, 4'h0, 0, 0, "after reset load");

        check("protocol violations", 32'(proto_err), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
